// File: rtl/io_write_buffer_pkg.sv
// Shared constants for the IO write buffer: register offsets (addr[3:2])
// and STATUS / CTRL bit positions, plus a helper that packs STATUS.
package io_pkg;

  // Register offsets as seen on addr[3:2]
  localparam logic [1:0] IO_DATA_OFS   = 2'd0;
  localparam logic [1:0] IO_STATUS_OFS = 2'd1;
  localparam logic [1:0] IO_CTRL_OFS   = 2'd2;
  localparam logic [1:0] IO_OVF_OFS    = 2'd3;

  // STATUS layout
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_W   = 8;

  // CTRL layout
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_OVF_CLR_BIT = 1;

  // Pack the STATUS word; all unlisted bits read as zero.
  function automatic logic [31:0] status_word(input logic       full,
                                              input logic       empty,
                                              input logic [7:0] count);
    logic [31:0] w;
    w = '0;
    w[STATUS_FULL_BIT]                         = full;
    w[STATUS_EMPTY_BIT]                        = empty;
    w[STATUS_COUNT_LSB +: STATUS_COUNT_W]      = count;
    return w;
  endfunction

endpackage

// File: rtl/io_write_buffer_if.sv
// CPU data-memory port plus VGA image-word handshake for io_write_buffer.
// slave: the write buffer's view; master: the CPU/VGA side driving it.
interface io_write_buffer_if;
  logic        wEn;
  logic [31:0] addr;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic [31:0] image_word;
  logic        image_valid;
  logic        image_ready;

  modport slave (
    input  wEn, addr, dataIn, image_ready,
    output dataOut, image_word, image_valid
  );

  modport master (
    output wEn, addr, dataIn, image_ready,
    input  dataOut, image_word, image_valid
  );
endinterface

// File: rtl/io_write_buffer_sync_fifo.sv
// Single-clock FIFO with flush. Pointers wrap modulo DEPTH (power of two);
// count is one bit wider so full and empty are unambiguous. A push while
// full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  // Flush wins over a concurrent pop; a full FIFO takes a push only alongside a pop.
  assign w_pop_ok  = i_pop && !o_empty && !i_flush;
  assign w_push_ok = i_push && !i_flush && (!o_full || w_pop_ok);

  // Pointer and count update
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; entries are only read once the
    // count says they were written, so resetting them would buy nothing.
    if (rst_n && w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/io_write_buffer.sv
// Memory-mapped write buffer: CPU stores to DATA are queued and streamed to
// the VGA stage over a valid/ready handshake. Register window at IO_BASE:
// 0x0 DATA (W), 0x4 STATUS (R), 0x8 CTRL (W), 0xC overflow count (R).
// Optional feature: define IO_WBUF_OVERFLOW_CNT_EN to add the saturating
// dropped-push counter at 0xC (cleared by CTRL bit 1); otherwise 0xC reads 0.
module io_write_buffer
  import io_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [31:0] IO_BASE = 32'h0000_F000
) (
  input  logic               clk,
  input  logic               rst_n,
  io_write_buffer_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          w_hit;
  logic [1:0]    w_ofs;
  logic          w_data_wr;
  logic          w_ctrl_wr;
  logic          w_flush;
  logic          w_pop;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_head;
  logic [31:0]   w_ovf_rd;
  logic [31:0]   w_rd_data;
  logic [31:0]   r_data_out;
  logic          w_unused_bits;

  // Address decode: one register per cycle, byte lane bits ignored.
  assign w_hit     = (bus.addr[31:4] == IO_BASE[31:4]);
  assign w_ofs     = bus.addr[3:2];
  assign w_data_wr = bus.wEn && w_hit && (w_ofs == IO_DATA_OFS);
  assign w_ctrl_wr = bus.wEn && w_hit && (w_ofs == IO_CTRL_OFS);
  assign w_flush   = w_ctrl_wr && bus.dataIn[CTRL_FLUSH_BIT];

  assign w_pop     = bus.image_valid && bus.image_ready;
  // A push is lost only when the FIFO is full and nothing leaves this cycle.
  assign w_drop    = w_data_wr && w_full && !w_pop;

  assign w_unused_bits = ^{bus.addr[1:0], bus.dataIn[31:1]};

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (w_data_wr),
    .i_wdata (bus.dataIn),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.image_valid = !w_empty;
  assign bus.image_word  = w_head;

`ifdef IO_WBUF_OVERFLOW_CNT_EN
  logic [31:0] r_ovf_cnt;

  // Saturating count of dropped pushes, software-clearable through CTRL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (w_ctrl_wr && bus.dataIn[CTRL_OVF_CLR_BIT]) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + 32'd1;
    end
  end

  assign w_ovf_rd = r_ovf_cnt;
`else
  assign w_ovf_rd = '0;
`endif

  // Register read mux; STATUS reflects FIFO state before the sampling edge.
  always_comb begin
    // NOTE: default first so every path assigns w_rd_data and no latch is inferred.
    w_rd_data = '0;
    if (w_hit) begin
      case (w_ofs)
        IO_STATUS_OFS: w_rd_data = status_word(w_full, w_empty, 8'(w_count));
        IO_OVF_OFS:    w_rd_data = w_ovf_rd;
        default:       w_rd_data = '0;
      endcase
    end
  end

  // Registered CPU load data
  always_ff @(posedge clk) begin
    if (!rst_n) r_data_out <= '0;
    else        r_data_out <= w_rd_data;
  end

  assign bus.dataOut = r_data_out;

endmodule
